// File: rtl/div_share_arbiter.sv
// div_share_arbiter
//
// Shares one iterative divider between N requesters using round-robin
// arbitration. The winning requester's operands are latched, handed to the
// divider with a one-cycle start pulse, and the quotient/remainder are
// returned with a one-cycle one-hot acknowledge. Divide-by-zero is answered
// immediately without touching the divider, and a watchdog aborts an
// operation whose divider never reports done.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   req        level request per requester, held until its ack
//   req_a      dividend of requester i at [i*W +: W]
//   req_b      divisor of requester i at [i*W +: W]
//   ack        one-hot one-cycle acknowledge; rsp_* valid this cycle
//   rsp_q      quotient
//   rsp_r      remainder
//   rsp_err    00 ok, 01 divide-by-zero, 10 timeout
//   busy       high whenever not idle
//   div_start  one-cycle start pulse to the divider
//   div_a      dividend to the divider
//   div_b      divisor to the divider
//   div_q      divider quotient
//   div_r      divider remainder
//   div_done   divider done
module div_share_arbiter #(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 31
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   rsp_q,
    output logic [W-1:0]   rsp_r,
    output logic [1:0]     rsp_err,
    output logic           busy,
    output logic           div_start,
    output logic [W-1:0]   div_a,
    output logic [W-1:0]   div_b,
    input  logic [W-1:0]   div_q,
    input  logic [W-1:0]   div_r,
    input  logic           div_done
);

    localparam int GW     = (N > 1) ? $clog2(N) : 1;
    localparam int TW_MIN = $clog2(TIMEOUT + 1);
    localparam int TW     = (TW_MIN > 5) ? TW_MIN : 5;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state;
    logic [GW-1:0]  gnt;
    logic [GW-1:0]  ptr;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [TW-1:0]  timer;

    logic [GW-1:0]  sel;
    logic           found;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;

    function automatic logic [N-1:0] one_hot(input logic [GW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: scan ptr, ptr+1, ... wrapping modulo N, and take
    // the first asserted request. Wrapping is done explicitly so that
    // non-power-of-two N works.
    always_comb begin
        int idx;
        idx   = 0;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = GW'(idx);
            end
        end
    end

    assign sel_a = req_a[int'(sel)*W +: W];
    assign sel_b = req_b[int'(sel)*W +: W];

    // Single sequencing FSM. Every output is registered and is set on the
    // edge that enters the state in which it must be visible, so ack,
    // div_start and busy never depend combinationally on req.
    // div_done is only looked at in WAIT; a stale done elsewhere is ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            gnt       <= '0;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            timer     <= '0;
            ack       <= '0;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_err   <= ERR_OK;
            busy      <= 1'b0;
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
        end else begin
            ack       <= '0;
            div_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt   <= sel;
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        busy  <= 1'b1;
                        div_a <= sel_a;
                        div_b <= sel_b;
                        if (sel_b == '0) begin
                            // The divider would never finish; answer now.
                            state   <= S_RESP;
                            ack     <= one_hot(sel);
                            rsp_q   <= '0;
                            rsp_r   <= sel_a;
                            rsp_err <= ERR_DIV0;
                        end else begin
                            state     <= S_ISSUE;
                            div_start <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                    timer <= '0;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (div_done) begin
                        state   <= S_RESP;
                        ack     <= one_hot(gnt);
                        rsp_q   <= div_q;
                        rsp_r   <= div_r;
                        rsp_err <= ERR_OK;
                    end else if (timer == TW'(TIMEOUT)) begin
                        state   <= S_RESP;
                        ack     <= one_hot(gnt);
                        rsp_q   <= '0;
                        rsp_r   <= '0;
                        rsp_err <= ERR_TOUT;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    div_a <= '0;
                    div_b <= '0;
                    if (gnt == GW'(N - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= gnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    div_a <= '0;
                    div_b <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter
//
// Bench for div_share_arbiter with a behavioural divider of programmable
// latency and a hang mode. Directed vectors with hand-computed results,
// plus hand-written sequences for reset, fairness and operand changes.
module tb_div_share_arbiter;

    localparam int N       = 4;
    localparam int W       = 4;
    localparam int TIMEOUT = 31;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   ack;
    logic [W-1:0]   rsp_q;
    logic [W-1:0]   rsp_r;
    logic [1:0]     rsp_err;
    logic           busy;
    logic           div_start;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic [W-1:0]   div_q;
    logic [W-1:0]   div_r;
    logic           div_done;

    int checks = 0;
    int errors = 0;

    int lat_cfg = 5;
    bit hang    = 1'b0;

    always #5 clk = ~clk;

    div_share_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .ack(ack), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
        .busy(busy), .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .div_done(div_done)
    );

    // Behavioural divider: done drops on the start edge and rises lat_cfg
    // edges later, then stays high with stable results until the next start.
    // In hang mode done never rises.
    logic [W-1:0] m_q    = '0;
    logic [W-1:0] m_r    = '0;
    logic         m_done = 1'b0;
    int           m_cnt  = 0;

    always @(posedge clk) begin
        if (div_start) begin
            m_done <= 1'b0;
            m_cnt  <= lat_cfg;
            if (div_b != '0) begin
                m_q <= div_a / div_b;
                m_r <= div_a % div_b;
            end
        end else if (m_cnt > 0 && !hang) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
            end
        end
    end

    assign div_q    = m_q;
    assign div_r    = m_r;
    assign div_done = m_done;

    typedef struct {
        int idx;
        int a;
        int b;
        int lat;
        bit hang;
        int exp_q;
        int exp_r;
        int exp_err;
        int exp_cyc;
        int exp_starts;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Raises one request, waits (bounded) for its ack and checks the
    // response, the latency in cycles from the request and the start pulses.
    task automatic applyStimulus(input string tag, input int idx, input int a, input int b,
                                 input int exp_q, input int exp_r, input int exp_err,
                                 input int exp_cyc, input int exp_starts);
        int cyc;
        int starts;
        int sa;
        int sb;
        int got;
        req_a[idx*W +: W] = W'(a);
        req_b[idx*W +: W] = W'(b);
        req[idx]          = 1'b1;
        cyc    = 0;
        starts = 0;
        sa     = -1;
        sb     = -1;
        got    = 0;
        while (got == 0 && cyc < 80) begin
            tick();
            cyc++;
            if (div_start) begin
                starts++;
                sa = int'(div_a);
                sb = int'(div_b);
            end
            if (ack != '0) begin
                got = 1;
            end
        end
        req[idx] = 1'b0;
        checkOutput({tag, " ack_seen"}, got, 1);
        checkOutput({tag, " ack"}, int'(ack), 1 << idx);
        checkOutput({tag, " q"}, int'(rsp_q), exp_q);
        checkOutput({tag, " r"}, int'(rsp_r), exp_r);
        checkOutput({tag, " err"}, int'(rsp_err), exp_err);
        checkOutput({tag, " latency"}, cyc, exp_cyc);
        checkOutput({tag, " busy_resp"}, int'(busy), 1);
        checkOutput({tag, " starts"}, starts, exp_starts);
        if (exp_starts > 0) begin
            checkOutput({tag, " div_a"}, sa, a);
            checkOutput({tag, " div_b"}, sb, b);
        end
        tick();
        checkOutput({tag, " ack_after"}, int'(ack), 0);
        checkOutput({tag, " busy_after"}, int'(busy), 0);
        checkOutput({tag, " q_hold"}, int'(rsp_q), exp_q);
        checkOutput({tag, " err_hold"}, int'(rsp_err), exp_err);
        checkOutput({tag, " div_a_idle"}, int'(div_a), 0);
    endtask

    // All four requests held; each dropped on its own ack. Checks that the
    // grants come out in the expected rotation.
    task automatic fairnessRound(input string tag);
        int order[4];
        int got;
        int cyc;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(i + 8);
            req_b[i*W +: W] = W'(2);
            order[i]        = -1;
        end
        req = '1;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 100) begin
            tick();
            cyc++;
            if (ack != '0) begin
                checkOutput($sformatf("%s onehot%0d", tag, got), $countones(ack), 1);
                for (int k = 0; k < N; k++) begin
                    if (ack[k]) begin
                        order[got] = k;
                    end
                end
                got++;
                req = req & ~ack;
            end
        end
        req = '0;
        checkOutput({tag, " grants"}, got, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s order%0d", tag, i), order[i], i);
        end
        tick();
    endtask

    initial begin
        int cyc;
        int got;
        int acks;

        // idx, a, b, lat, hang, q, r, err, cycles-to-ack, starts
        vecs[0] = '{0, 13, 4, 5, 1'b0,  3, 1, 0,  8, 1};
        vecs[1] = '{2,  9, 0, 5, 1'b0,  0, 9, 1,  1, 0};
        vecs[2] = '{1,  7, 2, 5, 1'b1,  0, 0, 2, 34, 1};
        vecs[3] = '{1,  7, 2, 3, 1'b0,  3, 1, 0,  6, 1};
        vecs[4] = '{3, 15, 5, 1, 1'b0,  3, 0, 0,  4, 1};
        vecs[5] = '{0,  0, 7, 2, 1'b0,  0, 0, 0,  5, 1};
        vecs[6] = '{3, 15, 1, 8, 1'b0, 15, 0, 0, 11, 1};
        vecs[7] = '{1,  5, 7, 4, 1'b0,  0, 5, 0,  7, 1};

        rst   = 1'b0;
        req   = '0;
        req_a = '0;
        req_b = '0;
        tick();
        tick();
        rst = 1'b1;

        checkOutput("reset ack", int'(ack), 0);
        checkOutput("reset q", int'(rsp_q), 0);
        checkOutput("reset r", int'(rsp_r), 0);
        checkOutput("reset err", int'(rsp_err), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset start", int'(div_start), 0);
        checkOutput("reset div_a", int'(div_a), 0);
        checkOutput("reset div_b", int'(div_b), 0);

        for (int i = 0; i < 8; i++) begin
            lat_cfg = vecs[i].lat;
            hang    = vecs[i].hang;
            applyStimulus($sformatf("vec%0d", i), vecs[i].idx, vecs[i].a, vecs[i].b,
                          vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_err,
                          vecs[i].exp_cyc, vecs[i].exp_starts);
        end
        hang = 1'b0;

        // Reset while in WAIT, then let the divider finish late.
        lat_cfg       = 6;
        req_a[3:0]    = 4'd13;
        req_b[3:0]    = 4'd4;
        req[0]        = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("midrst busy_wait", int'(busy), 1);
        req = '0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("midrst ack", int'(ack), 0);
        checkOutput("midrst q", int'(rsp_q), 0);
        checkOutput("midrst r", int'(rsp_r), 0);
        checkOutput("midrst err", int'(rsp_err), 0);
        checkOutput("midrst busy", int'(busy), 0);
        checkOutput("midrst start", int'(div_start), 0);
        checkOutput("midrst div_a", int'(div_a), 0);
        checkOutput("midrst div_b", int'(div_b), 0);
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack != '0) begin
                acks++;
            end
        end
        checkOutput("midrst late_done_acks", acks, 0);
        lat_cfg = 3;
        applyStimulus("fresh3", 3, 15, 5, 3, 0, 0, 6, 1);

        // ptr is back at 0 after serving requester 3.
        lat_cfg = 2;
        fairnessRound("fair1");
        fairnessRound("fair2");

        // Operands change after the grant; the latched ones must be used.
        lat_cfg     = 4;
        req_a[3:0]  = 4'd8;
        req_b[3:0]  = 4'd2;
        req[0]      = 1'b1;
        tick();
        tick();
        tick();
        req_a[3:0] = 4'd1;
        cyc = 3;
        got = 0;
        while (got == 0 && cyc < 80) begin
            tick();
            cyc++;
            if (ack != '0) begin
                got = 1;
            end
        end
        req = '0;
        checkOutput("opchg ack_seen", got, 1);
        checkOutput("opchg ack", int'(ack), 1);
        checkOutput("opchg q", int'(rsp_q), 4);
        checkOutput("opchg r", int'(rsp_r), 0);
        checkOutput("opchg err", int'(rsp_err), 0);
        checkOutput("opchg latency", cyc, 7);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
